// File: rtl/mul_booth_seq_pkg.sv
// Shared Mini SRC definitions for the sequential Booth multiplier:
// FSM state encoding, radix-4 recode select encoding and the recode table.
package mul_booth_seq_pkg;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Radix-4 Booth partial-product selection.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_sel_t;

  // Map the bit triple {lo[1:0], guard} to the multiple of M to add.
  function automatic booth_sel_t booth_select(input logic [2:0] triple);
    booth_sel_t sel;
    case (triple)
      3'b001, 3'b010: sel = PM;
      3'b011:         sel = P2M;
      3'b100:         sel = N2M;
      3'b101, 3'b110: sel = NM;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: turns the current multiplier bit triple into an
// E+1-bit addend (0, +M, +2M, -M or -2M) derived from the extended multiplicand.
module booth_r4_recode
  import mul_booth_seq_pkg::*;
#(
  parameter int E = 34
) (
  input  logic [2:0]   triple,
  input  logic [E-1:0] mcand,
  output logic [E:0]   addend
);

  booth_sel_t sel;
  logic [E:0] m1;
  logic [E:0] m2;

  assign sel = booth_select(triple);
  // One extra bit so that +/-2M always fits.
  assign m1  = {mcand[E-1], mcand};
  assign m2  = {mcand, 1'b0};

  // Addend multiplexer driven by the recoded select.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves addend unassigned (no latch).
    addend = '0;
    case (sel)
      PM:      addend = m1;
      P2M:     addend = m2;
      NM:      addend = -m1;
      N2M:     addend = -m2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Multi-cycle radix-4 Booth multiplier with start/done handshake.
// Retires two multiplier bits per clock; signed or unsigned operands;
// full 2*WIDTH-bit product, held until the next accepted start.
module mul_booth_seq
  import mul_booth_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int E  = WIDTH + 2;            // extended operand width
  localparam int AW = 2 * E + 1;            // accumulator {hi, lo, guard}
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] COUNT_INIT = CW'(E / 2);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  mul_state_t    state;
  logic [AW-1:0] acc;
  logic [E-1:0]  mcand;
  logic [CW-1:0] count;

  logic [E-1:0]  a_ext;
  logic [E-1:0]  b_ext;
  logic [E-1:0]  hi;
  logic [E-1:0]  lo;
  logic          guard;
  logic [E:0]    addend;
  logic [E:0]    sum;
  logic [AW-1:0] acc_next;

  // Two extra bits let unsigned operands recode as non-negative values.
  assign a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  assign hi    = acc[AW-1:E+1];
  assign lo    = acc[E:1];
  assign guard = acc[0];

  booth_r4_recode #(.E(E)) u_recode (
    .triple ({lo[1:0], guard}),
    .mcand  (mcand),
    .addend (addend)
  );

  // Add in E+1 bits, then arithmetic shift of the whole accumulator by two.
  assign sum      = {hi[E-1], hi} + addend;
  assign acc_next = {sum[E], sum, lo[E-1:1]};

  // Control FSM, iteration counter, accumulator and registered outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= {{E{1'b0}}, b_ext, 1'b0};
            mcand <= a_ext;
            count <= COUNT_INIT;
            ready <= 1'b0;
            state <= RUN;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            // Cancel wins over completion; result keeps its old value.
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count - COUNT_LAST;
            if (count == COUNT_LAST) begin
              result <= acc_next[2*WIDTH:1];
              done   <= 1'b1;
              ready  <= 1'b1;
              state  <= DONE;
            end
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: a WIDTH=32 instance for directed
// handshake/boundary scenarios and a WIDTH=8 instance for random operands.
// Expected products are queued at start and compared when done pulses.
`timescale 1ns/1ps
module tb_mul_booth_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear_n;

  logic        start32, abort32, sgn32;
  logic [31:0] a32, b32;
  logic        ready32, done32;
  logic [63:0] result32;

  logic        start8, abort8, sgn8;
  logic [7:0]  a8, b8;
  logic        ready8, done8;
  logic [15:0] result8;

  int checks = 0;
  int errors = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [63:0] last32;
  logic [63:0] exp32;
  logic [15:0] exp8;

  mul_booth_seq #(.WIDTH(32)) dut32 (
    .clock(clk), .clear_n(clear_n), .start(start32), .abort(abort32),
    .is_signed(sgn32), .a(a32), .b(b32),
    .ready(ready32), .done(done32), .result(result32)
  );

  mul_booth_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .clear_n(clear_n), .start(start8), .abort(abort8),
    .is_signed(sgn8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .result(result8)
  );

  // Reference: low 2W bits of the product of the 2W-bit extended operands.
  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'b0, x};
    ye = s ? {{8{y[7]}}, y} : {8'b0, y};
    return xe * ye;
  endfunction

  // Scoreboard for the 32-bit instance: every done pops one expected product.
  always @(negedge clk) begin
    if (done32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL done32_unexpected: done pulse with result %h, none expected", result32);
      end else begin
        exp32 = q32.pop_front();
        if (result32 !== exp32) begin
          errors++;
          $display("FAIL result32: got %h expected %h", result32, exp32);
        end
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: done pulse with result %h, none expected", result8);
      end else begin
        exp8 = q8.pop_front();
        if (result8 !== exp8) begin
          errors++;
          $display("FAIL result8: got %h expected %h", result8, exp8);
        end
      end
    end
  end

  // Drive one request; returns after the accepting edge with start low again.
  task automatic start_op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                            input logic push);
    @(posedge clk); #1;
    a32 = x; b32 = y; sgn32 = s; start32 = 1'b1;
    if (push) begin
      q32.push_back(model32(x, y, s));
      last32 = model32(x, y, s);
    end
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  // Count falling edges after the accept edge until done (bounded).
  task automatic wait_done32(output int n, output logic r1);
    n = 0;
    r1 = 1'bx;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) r1 = ready32;
    end while (!done32 && n < 60);
  endtask

  task automatic test_reset();
    clear_n = 1'b1;
    start32 = 0; abort32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
    start8  = 0; abort8  = 0; sgn8  = 0; a8  = '0; b8  = '0;
    last32 = '0;
    #1 clear_n = 1'b0;
    #2;
    checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL reset_ready32: got %b expected 1", ready32); end
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done32: got %b expected 0", done32); end
    checks++; if (result32 !== 64'h0) begin errors++; $display("FAIL reset_result32: got %h expected 0", result32); end
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b expected 1", ready8); end
    checks++; if (result8 !== 16'h0) begin errors++; $display("FAIL reset_result8: got %h expected 0", result8); end
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[8];
    int n;
    logic r1;
    vecs[0] = '{32'd7,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1};
    vecs[4] = '{32'h0,         32'h1234_5678, 1'b1, 64'h0};
    vecs[5] = '{32'hDEAD_BEEF, 32'h0,         1'b0, 64'h0};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      a32 = vecs[i].a; b32 = vecs[i].b; sgn32 = vecs[i].s; start32 = 1'b1;
      q32.push_back(vecs[i].exp);
      last32 = vecs[i].exp;
      @(posedge clk); #1;
      start32 = 1'b0;
      wait_done32(n, r1);
      checks++;
      if (n != 18) begin errors++; $display("FAIL latency32[%0d]: got %0d cycles expected 18", i, n); end
      checks++;
      if (r1 !== 1'b0) begin errors++; $display("FAIL ready_in_run[%0d]: got %b expected 0", i, r1); end
      @(negedge clk);
      checks++;
      if (done32 !== 1'b0 || ready32 !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse_width[%0d]: done %b ready %b expected done 0 ready 1", i, done32, ready32);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic r1;
    start_op32(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1);
    wait_done32(n, r1);
    checks++;
    if (n != 18) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 18", n); end
    // Still in the DONE cycle: issue the next op, with abort asserted (ignored here).
    a32 = 32'd5; b32 = 32'd6; sgn32 = 1'b1; start32 = 1'b1; abort32 = 1'b1;
    q32.push_back(64'd30);
    last32 = 64'd30;
    @(posedge clk); #1;
    start32 = 1'b0; abort32 = 1'b0;
    wait_done32(n, r1);
    checks++;
    if (r1 !== 1'b0) begin errors++; $display("FAIL b2b_no_idle: ready got %b expected 0", r1); end
    checks++;
    if (n != 18) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 18", n); end
  endtask

  task automatic test_start_in_run();
    int n;
    start_op32(32'd1000, 32'hFFFF_FFB3, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        a32 = 32'h1111_1111; b32 = 32'h2222_2222; sgn32 = 1'b0; start32 = 1'b1;
        checks++;
        if (ready32 !== 1'b0) begin errors++; $display("FAIL start_in_run_ready: got %b expected 0", ready32); end
        @(posedge clk); #1;
        start32 = 1'b0;
      end
    end while (!done32 && n < 60);
    checks++;
    if (n != 18) begin errors++; $display("FAIL start_in_run_latency: got %0d expected 18", n); end
  endtask

  task automatic test_abort(input int at_cycle);
    int n;
    int pulses;
    start_op32(32'd123, 32'd456, 1'b0, 1'b0);
    for (n = 1; n <= at_cycle; n++) @(negedge clk);
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    @(negedge clk);
    checks++;
    if (ready32 !== 1'b1) begin errors++; $display("FAIL abort%0d_ready: got %b expected 1", at_cycle, ready32); end
    checks++;
    if (result32 !== last32) begin errors++; $display("FAIL abort%0d_result: got %h expected %h", at_cycle, result32, last32); end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done32) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort%0d_done: got %0d pulses expected 0", at_cycle, pulses); end
  endtask

  task automatic test_clear_mid_run();
    int pulses;
    start_op32(32'd99, 32'd99, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    clear_n = 1'b0;
    #1;
    checks++;
    if (ready32 !== 1'b1 || done32 !== 1'b0 || result32 !== 64'h0) begin
      errors++;
      $display("FAIL clear_async: ready %b done %b result %h expected 1 0 0", ready32, done32, result32);
    end
    @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    last32 = '0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL clear_done: got %0d pulses expected 0", pulses); end
    checks++;
    if (ready32 !== 1'b1) begin errors++; $display("FAIL clear_idle_ready: got %b expected 1", ready32); end
  endtask

  task automatic test_after_clear();
    int n;
    logic r1;
    start_op32(32'hFFFF_FFF0, 32'd3, 1'b1, 1'b1);
    wait_done32(n, r1);
    checks++;
    if (n != 18) begin errors++; $display("FAIL after_clear_latency: got %0d expected 18", n); end
  endtask

  task automatic test_random_w8();
    logic [7:0] x, y;
    logic s;
    int n;
    for (int i = 0; i < 48; i++) begin
      case (i)
        0: begin x = 8'h80; y = 8'h80; s = 1'b1; end
        1: begin x = 8'hFF; y = 8'hFF; s = 1'b0; end
        2: begin x = 8'hFF; y = 8'hFF; s = 1'b1; end
        3: begin x = 8'h00; y = 8'h9C; s = 1'b1; end
        default: begin
          x = 8'($urandom);
          y = 8'($urandom);
          s = 1'($urandom_range(1));
        end
      endcase
      @(posedge clk); #1;
      a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
      q8.push_back(model8(x, y, s));
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done8 && n < 30);
      checks++;
      if (n != 6) begin errors++; $display("FAIL latency8[%0d]: got %0d expected 6", i, n); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    @(negedge clk);
    test_start_in_run();
    @(negedge clk);
    test_abort(10);
    test_abort(17);
    test_clear_mid_run();
    test_after_clear();
    test_random_w8();
    repeat (4) @(negedge clk);
    checks++;
    if (q32.size() != 0) begin errors++; $display("FAIL pending32: %0d results never produced", q32.size()); end
    checks++;
    if (q8.size() != 0) begin errors++; $display("FAIL pending8: %0d results never produced", q8.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
